// File: rtl/mux_select_sequencer.sv
// -----------------------------------------------------------------------------
// mux_select_sequencer
//
// Generates the 2-bit select code for a 4-to-1 lab multiplexer. The code scans
// 0,1,2,3,0,... either automatically every DIV clocks (enable=1) or one step
// per push-button rising edge, and can be loaded directly with any value.
// Single-cycle tick/wrap strobes accompany each advance.
//
// Parameters:
//   DIV      clock cycles per automatic advance (>= 2)
//   CW       divider counter width, 2**CW >= DIV
// Ports:
//   clock    system clock, rising-edge active
//   resetn   asynchronous active-low reset
//   enable   1 = auto advance every DIV cycles, 0 = divider cleared and held
//   step     asynchronous active-high button level; each rising edge advances
//   load     synchronous load request (level), highest priority
//   load_sel value loaded into sel while load=1
//   sel      registered select code to the mux (sel[1] high, sel[0] low)
//   tick     registered one-cycle pulse after every advance
//   wrap     registered one-cycle pulse after an advance from 3 to 0
// -----------------------------------------------------------------------------
module mux_select_sequencer #(
  parameter int DIV = 50000000,
  parameter int CW  = 26
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] load_sel,
  output logic [1:0] sel,
  output logic       tick,
  output logic       wrap
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s3_q, s3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic          step_edge;
  logic          auto_adv;
  logic          adv;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    // Two-flop synchronizer for the asynchronous button, plus one more stage
    // so the rising edge is detected on already-synchronized values.
    s1_d = step;
    s2_d = s1_q;
    s3_d = s2_q;
    step_edge = s2_q & ~s3_q;

    auto_adv = enable && (cnt_q == CNT_LAST);

    if (!enable || auto_adv) cnt_d = '0;
    else                     cnt_d = cnt_q + CW'(1);

    // Auto and step requests merge: coincident requests give a single +1.
    adv = auto_adv | step_edge;

    sel_d  = sel_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;

    if (load) begin
      // Load wins over any advance and restarts the auto interval.
      sel_d = load_sel;
      cnt_d = '0;
    end else if (adv) begin
      sel_d  = sel_q + 2'd1;
      tick_d = 1'b1;
      wrap_d = (sel_q == 2'd3);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign sel  = sel_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_select_sequencer
//
// Drives mux_select_sequencer (DIV=4) through directed scenarios followed by
// randomized enable/step/load/reset traffic. A behavioural model tracks the
// expected sel/tick/wrap from the rules (run length of enabled cycles, step
// sample history) and is compared against the DUT every cycle; directed
// scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_mux_select_sequencer;

  localparam int DIV = 4;
  localparam int CW  = 3;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic       step;
  logic       load;
  logic [1:0] load_sel;
  logic [1:0] sel;
  logic       tick;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  mux_select_sequencer #(.DIV(DIV), .CW(CW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .step     (step),
    .load     (load),
    .load_sel (load_sel),
    .sel      (sel),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   run      : enabled, non-load edges since the interval last restarted;
  //              an auto advance happens whenever run reaches a multiple of DIV
  //   hist[i]  : step level sampled i edges ago; a press registers when the
  //              sample two edges back is high and the one three back is low
  // ---------------------------------------------------------------------------
  int m_sel  = 0;
  int m_tick = 0;
  int m_wrap = 0;
  int run    = 0;
  int hist [1:3] = '{0, 0, 0};

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_sel = 0; m_tick = 0; m_wrap = 0; run = 0;
        hist = '{0, 0, 0};
      end else begin
        bit press, auto_hit;
        press    = (hist[2] == 1) && (hist[3] == 0);
        auto_hit = 1'b0;
        if (load) begin
          m_sel = int'(load_sel); m_tick = 0; m_wrap = 0; run = 0;
        end else begin
          if (enable) begin
            run++;
            auto_hit = (run % DIV) == 0;
          end else begin
            run = 0;
          end
          if (auto_hit || press) begin
            m_tick = 1;
            m_wrap = (m_sel == 3) ? 1 : 0;
            m_sel  = (m_sel + 1) % 4;
          end else begin
            m_tick = 0; m_wrap = 0;
          end
        end
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = int'(step);
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      check("sel_vs_model",  int'(sel),  m_sel);
      check("tick_vs_model", int'(tick), m_tick);
      check("wrap_vs_model", int'(wrap), m_wrap);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    int ticks, wraps, step_left;

    resetn = 1'b0; enable = 1'b0; step = 1'b0; load = 1'b0; load_sel = 2'd0;
    cyc(2);
    check("reset_sel",  int'(sel),  0);
    check("reset_tick", int'(tick), 0);
    check("reset_wrap", int'(wrap), 0);

    // Auto scan from reset release.
    enable = 1'b1;
    resetn = 1'b1;
    ticks = 0; wraps = 0;
    for (int e = 1; e <= 16; e++) begin
      cyc(1);
      ticks += int'(tick);
      wraps += int'(wrap);
      if (e % 4 == 0) check("auto_scan_sel", int'(sel), (e / 4) % 4);
      if (e == 3)     check("auto_scan_hold", int'(sel), 0);
    end
    check("auto_scan_ticks", ticks, 4);
    check("auto_scan_wraps", wraps, 1);
    check("auto_scan_wrap_at_0", int'(wrap), 1);

    // Asynchronous reset mid-count with sel=2.
    cyc(8);
    check("pre_reset_sel", int'(sel), 2);
    cyc(2);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_sel",  int'(sel),  0);
    check("async_reset_tick", int'(tick), 0);
    check("async_reset_wrap", int'(wrap), 0);
    cyc(2);
    check("held_reset_sel", int'(sel), 0);
    enable = 1'b0;
    resetn = 1'b1;

    // Step with enable=0: 2-edge latency, one advance per press.
    step = 1'b1;
    cyc(1); check("step_k_sel",   int'(sel), 0);
    cyc(1); check("step_k1_sel",  int'(sel), 0);
    cyc(1); check("step_k2_sel",  int'(sel), 1);
    check("step_k2_tick", int'(tick), 1);
    cyc(7); check("step_held_sel", int'(sel), 1);
    step = 1'b0;
    cyc(3);
    step = 1'b1;
    cyc(3); check("step_second_sel", int'(sel), 2);
    cyc(5);
    step = 1'b0;
    cyc(3);
    check("step_no_extra_sel", int'(sel), 2);

    // Coincidence: press lands on the auto-advance edge (edge 4).
    enable = 1'b1;
    cyc(1);
    step = 1'b1;
    cyc(1);
    cyc(1); check("coinc_pre_sel", int'(sel), 2);
    cyc(1); check("coinc_sel", int'(sel), 3);
    check("coinc_tick", int'(tick), 1);
    cyc(1); check("coinc_tick_off", int'(tick), 0);
    step = 1'b0;
    cyc(3); check("coinc_next_sel", int'(sel), 0);
    check("coinc_next_wrap", int'(wrap), 1);

    // Load priority over a coincident auto advance at edge 16.
    cyc(4); check("load_pre_sel", int'(sel), 1);
    cyc(3);
    load = 1'b1; load_sel = 2'd3;
    cyc(1);
    check("load_sel",  int'(sel),  3);
    check("load_tick", int'(tick), 0);
    check("load_wrap", int'(wrap), 0);
    load = 1'b0;
    cyc(3); check("load_hold_sel", int'(sel), 3);
    cyc(1); check("load_after_sel", int'(sel), 0);
    check("load_after_wrap", int'(wrap), 1);

    // Enable toggle restarts the full interval.
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(3);
    enable = 1'b0;
    cyc(1); check("toggle_gap_sel", int'(sel), 0);
    enable = 1'b1;
    cyc(3); check("toggle_hold_sel", int'(sel), 0);
    cyc(1); check("toggle_adv_sel", int'(sel), 1);
    check("toggle_adv_tick", int'(tick), 1);

    // Randomized traffic; the every-cycle compare does the checking.
    step_left = 0;
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 39) == 0);
      load_sel = 2'($urandom_range(0, 3));
      if (step_left == 0) begin
        step      = ~step;
        step_left = $urandom_range(1, 6);
      end else begin
        step_left--;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
      end else begin
        cyc(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
